// File: rtl/regfile_writeback_queue_if.sv
// Handshake and register-file write bundle for the writeback queue.
// master = producers/decode/regfile side, slave = the queue itself.
interface regfile_writeback_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic             Flush;

    logic             Alu_Valid;
    logic             Alu_Ready;
    logic [AW-1:0]    Alu_Awr;
    logic [DW-1:0]    Alu_Din;

    logic             Mem_Valid;
    logic             Mem_Ready;
    logic [AW-1:0]    Mem_Awr;
    logic [DW-1:0]    Mem_Din;

    logic [AW-1:0]    Awr;
    logic [DW-1:0]    Din;
    logic             WrEn;

    logic [AW-1:0]    Ard1;
    logic [AW-1:0]    Ard2;
    logic             Pend1;
    logic             Pend2;

    logic [CNT_W-1:0] Count;

    modport master (
        output Flush,
        output Alu_Valid, Alu_Awr, Alu_Din,
        output Mem_Valid, Mem_Awr, Mem_Din,
        output Ard1, Ard2,
        input  Alu_Ready, Mem_Ready,
        input  Awr, Din, WrEn,
        input  Pend1, Pend2, Count
    );

    modport slave (
        input  Flush,
        input  Alu_Valid, Alu_Awr, Alu_Din,
        input  Mem_Valid, Mem_Awr, Mem_Din,
        input  Ard1, Ard2,
        output Alu_Ready, Mem_Ready,
        output Awr, Din, WrEn,
        output Pend1, Pend2, Count
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue merging ALU and load results into the register-file
// write port, with read-after-write pending flags for the decode stage.
module regfile_writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    regfile_writeback_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            slots [DEPTH];

    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              alu_ready;
    logic              mem_ready;
    logic              alu_push;
    logic              mem_push;
    logic              pop;
    logic [PTR_W-1:0]  wr_idx_alu;
    logic [PTR_W-1:0]  wr_idx_mem;
    logic [PTR_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              pend1;
    logic              pend2;

    // Readiness is judged on the registered count only; an r0 ALU write takes no slot.
    always_comb begin
        alu_ready  = (count <= CNT_W'(DEPTH - 1));
        alu_push   = bus.Alu_Valid && alu_ready && (bus.Alu_Awr != '0);
        mem_ready  = (count <= CNT_W'(DEPTH - 2)) || (alu_ready && !alu_push);
        mem_push   = bus.Mem_Valid && mem_ready && (bus.Mem_Awr != '0);
        pop        = (count != '0);

        wr_idx_alu = wr_ptr[PTR_W-1:0];
        wr_idx_mem = wr_idx_alu + PTR_W'(alu_push);
        rd_idx     = rd_ptr[PTR_W-1:0];

        wr_ptr_nxt = wr_ptr + CNT_W'(alu_push) + CNT_W'(mem_push);
        rd_ptr_nxt = rd_ptr + CNT_W'(pop);
        count_nxt  = count + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);
    end

    // Pointer and occupancy state; Flush wins over push and pop.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage needs no reset: only occupied slots are ever observed.
    always_ff @(posedge Clk) begin
        if (!bus.Flush) begin
            if (alu_push) begin
                slots[wr_idx_alu] <= entry_t'{addr: bus.Alu_Awr, data: bus.Alu_Din};
            end
            if (mem_push) begin
                slots[wr_idx_mem] <= entry_t'{addr: bus.Mem_Awr, data: bus.Mem_Din};
            end
        end
    end

    // Hazard scan over occupied slots, starting at the head.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = '0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_idx + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (slots[idx].addr == bus.Ard1) pend1 = 1'b1;
                if (slots[idx].addr == bus.Ard2) pend2 = 1'b1;
            end
        end
        if (bus.Ard1 == '0) pend1 = 1'b0;
        if (bus.Ard2 == '0) pend2 = 1'b0;
    end

    always_comb begin
        bus.Alu_Ready = alu_ready;
        bus.Mem_Ready = mem_ready;
        bus.WrEn      = pop;
        bus.Awr       = pop ? slots[rd_idx].addr : '0;
        bus.Din       = pop ? slots[rd_idx].data : '0;
        bus.Pend1     = pend1;
        bus.Pend2     = pend2;
        bus.Count     = count;
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized self-checking bench for regfile_writeback_queue against a
// queue-based reference model and a shadow register file.
module tb_regfile_writeback_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic rst_n;

    regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    ent_t        q [$];
    logic [31:0] exp_rf [32];
    logic [31:0] obs_rf [32];
    logic        alu_stall;
    logic        mem_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model at the edge.
    task automatic do_cycle(input logic fl,
                            input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md,
                            input logic [4:0] r1, input logic [4:0] r2);
        ent_t hd;
        logic ar, mr, ae, me, p1, p2;
        bus.Flush     = fl;
        bus.Alu_Valid = av;
        bus.Alu_Awr   = aa;
        bus.Alu_Din   = ad;
        bus.Mem_Valid = mv;
        bus.Mem_Awr   = ma;
        bus.Mem_Din   = md;
        bus.Ard1      = r1;
        bus.Ard2      = r2;
        #1;
        ar = (q.size() < DEPTH);
        ae = av && ar && (aa != 5'd0);
        mr = (q.size() + 2 <= DEPTH) || (ar && !ae);
        me = mv && mr && (ma != 5'd0);
        p1 = 1'b0;
        p2 = 1'b0;
        foreach (q[i]) begin
            if (q[i].a == r1) p1 = 1'b1;
            if (q[i].a == r2) p2 = 1'b1;
        end
        if (r1 == 5'd0) p1 = 1'b0;
        if (r2 == 5'd0) p2 = 1'b0;
        hd = (q.size() != 0) ? q[0] : '0;

        check("count",     64'(bus.Count),     64'(q.size()));
        check("wren",      64'(bus.WrEn),      64'(q.size() != 0));
        check("awr",       64'(bus.Awr),       64'(hd.a));
        check("din",       64'(bus.Din),       64'(hd.d));
        check("alu_ready", 64'(bus.Alu_Ready), 64'(ar));
        check("mem_ready", 64'(bus.Mem_Ready), 64'(mr));
        check("pend1",     64'(bus.Pend1),     64'(p1));
        check("pend2",     64'(bus.Pend2),     64'(p2));

        if (bus.WrEn === 1'b1) obs_rf[bus.Awr] = bus.Din;
        alu_stall = av && !ar;
        mem_stall = mv && !mr;

        @(posedge clk);
        if (q.size() != 0) begin
            exp_rf[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (fl) begin
            q.delete();
        end else begin
            if (ae) q.push_back(ent_t'{a: aa, d: ad});
            if (me) q.push_back(ent_t'{a: ma, d: md});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input logic [4:0] r1, input logic [4:0] r2);
        for (int unsigned i = 0; i < n; i++)
            do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    function automatic logic [4:0] pick_ard();
        if (q.size() != 0 && $urandom_range(0, 1) == 1)
            return q[$urandom_range(0, q.size() - 1)].a;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        logic        av, mv, fl;
        logic [4:0]  aa, ma;
        logic [31:0] ad, md;

        n_cmp     = 0;
        n_err     = 0;
        alu_stall = 1'b0;
        mem_stall = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_rf[i] = 32'd0;
            obs_rf[i] = 32'd0;
        end
        rst_n         = 1'b0;
        bus.Flush     = 1'b0;
        bus.Alu_Valid = 1'b0;
        bus.Alu_Awr   = 5'd0;
        bus.Alu_Din   = 32'd0;
        bus.Mem_Valid = 1'b0;
        bus.Mem_Awr   = 5'd0;
        bus.Mem_Din   = 32'd0;
        bus.Ard1      = 5'd0;
        bus.Ard2      = 5'd0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_count", 64'(bus.Count), 64'd0);
        check("rst_wren",  64'(bus.WrEn),  64'd0);
        rst_n = 1'b1;
        idle(10, 5'd1, 5'd2);

        // Single ALU write r5 = DEADBEEF
        do_cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("single_wren",  64'(bus.WrEn),  64'd1);
        check("single_awr",   64'(bus.Awr),   64'd5);
        check("single_din",   64'(bus.Din),   64'hDEADBEEF);
        check("single_pend1", 64'(bus.Pend1), 64'd1);
        idle(2, 5'd5, 5'd0);
        check("single_count", 64'(bus.Count), 64'd0);

        // Dual push to the same register: ALU first, then memory
        do_cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd4);
        check("dual_count", 64'(bus.Count), 64'd2);
        check("dual_din0",  64'(bus.Din),   64'h11);
        idle(1, 5'd3, 5'd0);
        check("dual_din1",  64'(bus.Din),   64'h22);
        idle(2, 5'd3, 5'd0);
        check("dual_rf_r3", 64'(obs_rf[3]), 64'h22);

        // Fill with two pushes per cycle, wrapping the pointers
        for (int unsigned i = 0; i < 8; i++)
            do_cycle(1'b0, 1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i),
                     5'(8 + i), 5'(20 + i));
        idle(5, 5'd9, 5'd21);

        // r0 filtering
        do_cycle(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd7, 32'h7, 5'd0, 5'd7);
        check("r0_count", 64'(bus.Count), 64'd1);
        check("r0_awr",   64'(bus.Awr),   64'd7);
        idle(2, 5'd0, 5'd7);

        // Flush with simultaneous push
        do_cycle(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
        do_cycle(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd3, 5'd4);
        check("pre_flush_count", 64'(bus.Count), 64'd3);
        do_cycle(1'b1, 1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6, 5'd5, 5'd6);
        check("flush_count", 64'(bus.Count), 64'd0);
        check("flush_wren",  64'(bus.WrEn),  64'd0);
        idle(2, 5'd5, 5'd6);

        // Asynchronous reset mid-drain
        do_cycle(1'b0, 1'b1, 5'd10, 32'hB0, 1'b1, 5'd11, 32'hB1, 5'd10, 5'd11);
        do_cycle(1'b0, 1'b1, 5'd12, 32'hB2, 1'b1, 5'd13, 32'hB3, 5'd12, 5'd13);
        bus.Alu_Valid = 1'b0;
        bus.Mem_Valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(bus.Count),     64'd0);
        check("arst_wren",  64'(bus.WrEn),      64'd0);
        check("arst_awr",   64'(bus.Awr),       64'd0);
        check("arst_din",   64'(bus.Din),       64'd0);
        check("arst_pend1", 64'(bus.Pend1),     64'd0);
        check("arst_aready",64'(bus.Alu_Ready), 64'd1);
        check("arst_mready",64'(bus.Mem_Ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 5'd12, 5'd13);

        // Randomized traffic with producer hold on stalls
        av = 1'b0; aa = 5'd0; ad = 32'd0;
        mv = 1'b0; ma = 5'd0; md = 32'd0;
        alu_stall = 1'b0;
        mem_stall = 1'b0;
        for (int unsigned cyc = 0; cyc < 600; cyc++) begin
            if (!alu_stall) begin
                av = ($urandom_range(0, 9) < 7);
                aa = 5'($urandom_range(0, 31));
                ad = $urandom;
            end
            if (!mem_stall) begin
                mv = ($urandom_range(0, 9) < 6);
                ma = 5'($urandom_range(0, 31));
                md = $urandom;
            end
            fl = ($urandom_range(0, 59) == 0);
            do_cycle(fl, av, aa, ad, mv, ma, md, pick_ard(), pick_ard());
        end
        idle(DEPTH + 2, 5'd0, 5'd0);

        // Shadow register file must match what the DUT issued
        for (int i = 1; i < 32; i++)
            check("rf_final", 64'(obs_rf[i]), 64'(exp_rf[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
